// File: rtl/fmap_buffer.sv
// Kernel + feature-map scratchpad: sequences the host load, then serves two fmap read
// ports and one kernel read port, each with a fixed one-cycle registered latency.
module fmap_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load_start,
  input  logic          i_load_valid,
  input  logic [DW-1:0] i_load_data,
  output logic          o_load_ready,
  output logic          o_loaded,
  input  logic          i_rd1_en,
  input  logic [AW-1:0] i_rd1_addr,
  output logic [DW-1:0] o_rd1_data,
  output logic          o_rd1_valid,
  input  logic          i_rd2_en,
  input  logic [AW-1:0] i_rd2_addr,
  output logic [DW-1:0] o_rd2_data,
  output logic          o_rd2_valid,
  input  logic          i_krd_en,
  input  logic [3:0]    i_krd_addr,
  output logic [DW-1:0] o_krd_data,
  output logic          o_krd_valid,
  output logic          o_err
);
  localparam int FSIZE = IMG_W * IMG_H;
  localparam int KSIZE = K * K;
  localparam int CW    = $clog2(FSIZE);
  localparam int KIW   = $clog2(KSIZE);
  localparam logic [CW-1:0] KLAST = CW'(KSIZE - 1);
  localparam logic [CW-1:0] FLAST = CW'(FSIZE - 1);
  localparam logic [AW-1:0] FMAX  = AW'(FSIZE - 1);
  localparam logic [3:0]    KMAX  = 4'(KSIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD_KERNEL, LOAD_FMAP, SERVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] kmem [KSIZE];
  logic [DW-1:0] fmem [FSIZE];
  logic          xfer, kwr, fwr;
  logic          ok1, ok2, okk, bad;

  assign o_load_ready = (state == LOAD_KERNEL) || (state == LOAD_FMAP);
  assign o_loaded     = (state == SERVE);
  // A start pulse discards any byte offered in the same cycle.
  assign xfer         = i_load_valid && o_load_ready && !i_load_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kwr       = 1'b0;
    fwr       = 1'b0;
    if (i_load_start) begin
      state_nxt = LOAD_KERNEL;
      cnt_nxt   = '0;
    end else if (xfer) begin
      cnt_nxt = cnt + CW'(1);
      if (state == LOAD_KERNEL) begin
        kwr = 1'b1;
        if (cnt == KLAST) begin
          state_nxt = LOAD_FMAP;
          cnt_nxt   = '0;
        end
      end else begin
        fwr = 1'b1;
        if (cnt == FLAST) state_nxt = SERVE;
      end
    end
  end

  // Storage is deliberately not reset; reads outside SERVE never expose it.
  always_ff @(posedge i_clk) begin
    if (kwr) kmem[cnt[KIW-1:0]] <= i_load_data;
    if (fwr) fmem[cnt] <= i_load_data;
  end

  assign ok1 = (state == SERVE) && (i_rd1_addr <= FMAX);
  assign ok2 = (state == SERVE) && (i_rd2_addr <= FMAX);
  assign okk = (state == SERVE) && (i_krd_addr <= KMAX);
  assign bad = (i_rd1_en && !ok1) || (i_rd2_en && !ok2) || (i_krd_en && !okk);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rd1_valid <= 1'b0;
      o_rd1_data  <= '0;
      o_rd2_valid <= 1'b0;
      o_rd2_data  <= '0;
      o_krd_valid <= 1'b0;
      o_krd_data  <= '0;
      o_err       <= 1'b0;
    end else begin
      o_rd1_valid <= i_rd1_en;
      o_rd2_valid <= i_rd2_en;
      o_krd_valid <= i_krd_en;
      if (i_rd1_en) o_rd1_data <= ok1 ? fmem[i_rd1_addr] : '0;
      if (i_rd2_en) o_rd2_data <= ok2 ? fmem[i_rd2_addr] : '0;
      if (i_krd_en) o_krd_data <= okk ? kmem[i_krd_addr] : '0;
      // Start takes priority over a bad read in the same cycle.
      if (i_load_start) o_err <= 1'b0;
      else if (bad)     o_err <= 1'b1;
    end
  end
endmodule

// File: doc/fmap_buffer.md
# fmap_buffer

Scratchpad responder that serves the convolution engine's read traffic. The host streams in a 3x3 kernel and a 28x28 8-bit feature map. The buffer then answers two independent feature-map read ports (window rows at stride offsets) and one kernel read port, each with fixed one-cycle latency. It sits between the host load path and the convolution datapath, and owns load sequencing and address-range checking.

## Interface
- IMG_W, 28, feature-map width in pixels
- IMG_H, 28, feature-map height in pixels
- K, 3, kernel edge; kernel holds K*K bytes
- DW, 8, data width
- AW, 10, feature-map address width; must satisfy 2^AW >= IMG_W*IMG_H
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_load_start  in  1  pulse: begin a new load sequence
- i_load_valid  in  1  load byte valid
- i_load_data  in  DW  load byte
- o_load_ready  out  1  buffer accepts load bytes
- o_loaded  out  1  kernel and feature map complete; reads are serviceable
- i_rd1_en, i_rd2_en  in  1  read request, ports 1/2
- i_rd1_addr, i_rd2_addr  in  AW  row-major pixel address, ports 1/2
- o_rd1_data, o_rd2_data  out  DW  read data, ports 1/2
- o_rd1_valid, o_rd2_valid  out  1  read data valid, ports 1/2
- i_krd_en  in  1  kernel read request
- i_krd_addr  in  4  kernel index, row-major (0..K*K-1)
- o_krd_data  out  DW  kernel read data
- o_krd_valid  out  1  kernel data valid
- o_err  out  1  sticky error flag

## Operation
- States: IDLE, LOAD_KERNEL, LOAD_FMAP, SERVE.
- IDLE:
  - o_load_ready=0, o_loaded=0.
  - i_load_start -> LOAD_KERNEL.
- Load counter:
  - One counter; width must cover IMG_W*IMG_H-1.
  - Cleared on every i_load_start.
- Transfer: i_load_valid && o_load_ready.
- LOAD_KERNEL:
  - o_load_ready=1.
  - Each transfer writes kernel[cnt] and increments cnt.
  - Transfer with cnt==K*K-1 -> LOAD_FMAP, cnt cleared.
- LOAD_FMAP:
  - o_load_ready=1.
  - Each transfer writes fmap[cnt] and increments cnt.
  - Transfer with cnt==IMG_W*IMG_H-1 -> SERVE.
- SERVE:
  - o_loaded=1, o_load_ready=0.
  - Stays in SERVE until i_load_start or reset.
- i_load_start in any state, including mid-load or SERVE:
  - Next state LOAD_KERNEL, cnt=0, o_loaded=0, o_err cleared.
  - A transfer in the same cycle is dropped; start wins.
- Reads:
  - Ports 1, 2 and K are fully independent.
  - Ports 1 and 2 may hit the same or different addresses in the same cycle.
- Valid read: en=1, state==SERVE and address in range (fmap < IMG_W*IMG_H, kernel < K*K).
  - Returns the stored byte.
- Invalid read:
  - Returns data 0, valid still asserted, o_err set.
- Idle ports: en=0 -> valid=0 next cycle; data holds its last value.
- o_err:
  - Sticky; set by any invalid read.
  - Cleared only by reset or i_load_start.
- Memory arrays are not reset. Stale contents are never visible, because reads outside SERVE return 0.

## Timing
- Reset values:
  - State IDLE, cnt 0.
  - o_load_ready=0, o_loaded=0, o_err=0.
  - All o_*_valid=0, all o_*_data=0.
- Reset mid-load: returns to IDLE immediately; the partial load is abandoned, and reads then return 0 with o_err.
- Read latency: exactly 1 cycle. En/addr sampled at edge N; data/valid registered at edge N+1 for one cycle. Full throughput, one read per port per cycle.
- o_load_ready is a registered function of state.
  - It rises the cycle after i_load_start.
  - It falls the cycle after the final fmap transfer.
- o_loaded rises the cycle after the final fmap transfer.
- A read issued in the same cycle as the final fmap transfer is invalid (state not yet SERVE).
- A full load takes K*K + IMG_W*IMG_H = 793 transfers. With continuous valid, o_loaded rises 794 cycles after the i_load_start cycle.

## Test plan
- Load then dual read:
  - Stimulus: reset; pulse i_load_start; stream kernel 1..9, then fmap byte[a]=a[7:0] with continuous valid.
  - Response: o_loaded=1 at cycle 794. Read rd1 addr 29 and rd2 addr 31 in the same cycle -> next cycle data 29/31, both valids 1, o_err 0.
- Kernel read:
  - Stimulus: after the load above, i_krd_addr 0, then 8, on consecutive cycles.
  - Response: o_krd_data 1, then 9, valid each cycle.
- Backpressure gaps:
  - Stimulus: toggle i_load_valid every other cycle during the load.
  - Response: o_loaded rises after the 793rd accepted byte; contents identical to the continuous load.
- Out-of-range and early reads:
  - Stimulus: rd1 addr 784 in SERVE; krd addr 9; separately, rd2 addr 0 during LOAD_FMAP.
  - Response: data 0, valid 1, o_err 1 and stays 1 until i_load_start.
- Restart mid-load:
  - Stimulus: i_load_start at fmap cnt 100, with a valid byte in the same cycle.
  - Response: the byte is dropped; o_load_ready stays 1, o_loaded 0, o_err 0. The next byte is written to kernel[0].
- Async reset in SERVE:
  - Stimulus: assert i_rst between clock edges.
  - Response: o_loaded, o_load_ready and all valids go 0 immediately. After release, rd1 addr 0 -> data 0, o_err 1.
